// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : uDLX instruction fetch. Owns the PC and a single-outstanding
//            imem port, and feeds the IF/ID register through a 1-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_rd_en,
    input  logic                  stall,
    input  logic                  general_flush,
    input  logic                  select_new_pc,
    input  logic [PC_WIDTH-1:0]   new_pc_addr,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] if_id_inst,
    output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  fetch_busy
);

    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_imem_req;
    logic [PC_WIDTH-1:0]   r_imem_addr;
    logic [DATA_WIDTH-1:0] r_if_id_inst;
    logic [PC_WIDTH-1:0]   r_if_id_pc4;
    logic                  r_if_id_valid;
    logic [DATA_WIDTH-1:0] r_skid_inst;
    logic [PC_WIDTH-1:0]   r_skid_pc4;

    logic                  w_issue;
    logic [PC_WIDTH-1:0]   w_pc_seq;
    logic [PC_WIDTH-1:0]   w_addr_pc4;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_inst;
    logic [PC_WIDTH-1:0]   w_load_pc4;

    assign w_issue    = inst_rd_en & ~stall & ~select_new_pc;
    assign w_pc_seq   = r_pc + c_PC_STEP;
    assign w_addr_pc4 = r_imem_addr + c_PC_STEP;

    // Instruction offered to IF/ID this cycle: fresh ack data or the skid entry.
    always_comb begin
        w_load      = 1'b0;
        w_load_inst = r_skid_inst;
        w_load_pc4  = r_skid_pc4;
        case (r_state)
            S_WAIT: begin
                if (imem_ack && !stall) begin
                    w_load      = 1'b1;
                    w_load_inst = imem_data;
                    w_load_pc4  = w_addr_pc4;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
            r_skid_inst   <= NOP_INST;
            r_skid_pc4    <= '0;
        end else begin
            if (select_new_pc || general_flush) begin
                r_if_id_valid <= 1'b0;
                r_if_id_inst  <= NOP_INST;
            end else if (!stall) begin
                if (w_load) begin
                    r_if_id_valid <= 1'b1;
                    r_if_id_inst  <= w_load_inst;
                    r_if_id_pc4   <= w_load_pc4;
                end else begin
                    r_if_id_valid <= 1'b0;
                    r_if_id_inst  <= NOP_INST;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (select_new_pc) begin
                        r_pc <= new_pc_addr;
                    end else if (w_issue) begin
                        r_imem_addr <= r_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (select_new_pc) begin
                        r_pc <= new_pc_addr;
                        if (imem_ack) begin
                            r_imem_req <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            // Request cannot be withdrawn; wait for its ack and discard it.
                            r_state <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_seq;
                        if (stall) begin
                            r_skid_inst <= imem_data;
                            r_skid_pc4  <= w_addr_pc4;
                            r_imem_req  <= 1'b0;
                            r_state     <= S_HOLD;
                        end else if (w_issue) begin
                            r_imem_addr <= w_pc_seq;
                        end else begin
                            r_imem_req <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (select_new_pc) begin
                        r_pc <= new_pc_addr;
                    end
                    if (imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (select_new_pc) begin
                        r_pc        <= new_pc_addr;
                        r_skid_inst <= NOP_INST;
                        r_skid_pc4  <= '0;
                        r_state     <= S_IDLE;
                    end else if (!stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req       = r_imem_req;
    assign imem_addr      = r_imem_addr;
    assign if_id_inst     = r_if_id_inst;
    assign if_id_pc_plus4 = r_if_id_pc4;
    assign if_id_valid    = r_if_id_valid;
    assign fetch_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed scenarios plus randomized traffic against a
//            request/skid-queue reference model of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_rd_en;
    logic        stall;
    logic        general_flush;
    logic        select_new_pc;
    logic [31:0] new_pc_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_busy;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: one optional outstanding request, a skid queue, IF/ID.
    logic [31:0] m_pc;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_drop;
    logic [63:0] m_skid_q[$];
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;

    fetch_stage #(
        .PC_WIDTH   (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0),
        .NOP_INST   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_rd_en     (inst_rd_en),
        .stall          (stall),
        .general_flush  (general_flush),
        .select_new_pc  (select_new_pc),
        .new_pc_addr    (new_pc_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout n_checks=%0d", n_checks);
        $fatal(1);
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Advance one clock: present memory data, update the model, sample #1 after the edge.
    task automatic step();
        logic        ack_eff;
        logic        loaded;
        logic        may_issue;
        logic        skid_full;
        logic [31:0] n_pc;
        logic [31:0] l_inst;
        logic [31:0] l_pc4;
        logic [63:0] ent;
        imem_data = imem_ack ? memfn(m_addr) : $urandom;
        if (rst) begin
            m_pc = 32'h0; m_req = 1'b0; m_addr = 32'h0; m_drop = 1'b0;
            m_skid_q.delete();
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            ack_eff   = m_req && imem_ack;
            skid_full = (m_skid_q.size() != 0);
            loaded    = 1'b0;
            l_inst    = 32'h0;
            l_pc4     = 32'h0;
            n_pc      = m_pc;
            may_issue = 1'b0;
            if (ack_eff) begin
                if (!m_drop && !select_new_pc) begin
                    n_pc = m_addr + 32'd4;
                    if (stall) begin
                        m_skid_q.push_back({imem_data, m_addr + 32'd4});
                    end else begin
                        loaded = 1'b1; l_inst = imem_data; l_pc4 = m_addr + 32'd4;
                    end
                    may_issue = 1'b1;
                end
            end else if (!m_req && !skid_full) begin
                may_issue = 1'b1;
            end
            if (skid_full) begin
                if (select_new_pc) begin
                    m_skid_q.delete();
                end else if (!stall) begin
                    ent = m_skid_q.pop_front();
                    loaded = 1'b1; l_inst = ent[63:32]; l_pc4 = ent[31:0];
                end
            end
            if (select_new_pc) n_pc = new_pc_addr;
            if (ack_eff) begin
                m_req = 1'b0; m_drop = 1'b0;
            end else if (m_req && select_new_pc) begin
                m_drop = 1'b1;
            end
            if (may_issue && inst_rd_en && !stall && !select_new_pc) begin
                m_req = 1'b1; m_addr = n_pc;
            end
            if (general_flush || select_new_pc) begin
                m_valid = 1'b0; m_inst = 32'h0;
            end else if (!stall) begin
                if (loaded) begin
                    m_valid = 1'b1; m_inst = l_inst; m_pc4 = l_pc4;
                end else begin
                    m_valid = 1'b0; m_inst = 32'h0;
                end
            end
            m_pc = n_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_rd_en = 1'b0; stall = 1'b0; general_flush = 1'b0;
        select_new_pc = 1'b0; new_pc_addr = 32'h0; imem_ack = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; inst_rd_en = 1'b1;
        step();
        step();
        n_checks++;
        if ({imem_req, fetch_busy, if_id_valid} !== 3'b000)
            $display("FAIL reset_ctrl got=%b exp=000", {imem_req, fetch_busy, if_id_valid});
        else n_pass++;
        n_checks++;
        if ({imem_addr, if_id_inst, if_id_pc_plus4} !== 96'h0)
            $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", imem_addr, if_id_inst, if_id_pc_plus4);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        do_reset();
        inst_rd_en = 1'b1;
        step();
        imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(4 * (k + 1))})
                $display("FAIL zw_addr k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, 4 * (k + 1));
            else n_pass++;
            n_checks++;
            if ({if_id_valid, if_id_pc_plus4, if_id_inst} !== {1'b1, 32'(4 * (k + 1)), memfn(32'(4 * k))})
                $display("FAIL zw_ifid k=%0d got=%b/%h/%h exp=1/%h/%h", k, if_id_valid,
                         if_id_pc_plus4, if_id_inst, 4 * (k + 1), memfn(32'(4 * k)));
            else n_pass++;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_stall_skid();
        do_reset();
        inst_rd_en = 1'b1;
        step();
        imem_ack = 1'b1;
        step();
        step();
        stall = 1'b1;
        step();
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({imem_req, fetch_busy, if_id_valid, if_id_pc_plus4, if_id_inst} !==
                {1'b0, 1'b1, 1'b1, 32'd8, memfn(32'd4)})
                $display("FAIL skid_hold k=%0d got=%b%b%b/%h/%h exp=011/8/%h", k, imem_req, fetch_busy,
                         if_id_valid, if_id_pc_plus4, if_id_inst, memfn(32'd4));
            else n_pass++;
            if (k < 2) step();
        end
        stall = 1'b0;
        step();
        n_checks++;
        if ({if_id_valid, if_id_pc_plus4, if_id_inst, imem_req} !== {1'b1, 32'd12, memfn(32'd8), 1'b0})
            $display("FAIL skid_release got=%b/%h/%h/%b exp=1/c/%h/0", if_id_valid, if_id_pc_plus4,
                     if_id_inst, imem_req, memfn(32'd8));
        else n_pass++;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd12})
            $display("FAIL skid_next_fetch got=%b/%h exp=1/c", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        inst_rd_en = 1'b1;
        step();
        select_new_pc = 1'b1; new_pc_addr = 32'h100;
        step();
        select_new_pc = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, fetch_busy, if_id_valid} !== {1'b1, 32'h0, 1'b1, 1'b0})
            $display("FAIL rdw_drop got=%b/%h/%b/%b exp=1/0/1/0", imem_req, imem_addr, fetch_busy, if_id_valid);
        else n_pass++;
        step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, fetch_busy, if_id_valid} !== 3'b000)
            $display("FAIL rdw_ack_dropped got=%b exp=000", {imem_req, fetch_busy, if_id_valid});
        else n_pass++;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100})
            $display("FAIL rdw_new_fetch got=%b/%h exp=1/100", imem_req, imem_addr);
        else n_pass++;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({if_id_valid, if_id_pc_plus4, if_id_inst} !== {1'b1, 32'h104, memfn(32'h100)})
            $display("FAIL rdw_target_inst got=%b/%h/%h exp=1/104/%h", if_id_valid, if_id_pc_plus4,
                     if_id_inst, memfn(32'h100));
        else n_pass++;
    endtask

    task automatic test_redirect_ack();
        do_reset();
        inst_rd_en = 1'b1;
        step();
        imem_ack = 1'b1; select_new_pc = 1'b1; new_pc_addr = 32'h200;
        step();
        imem_ack = 1'b0; select_new_pc = 1'b0;
        n_checks++;
        if ({imem_req, if_id_valid, if_id_inst} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL rda_discard got=%b/%b/%h exp=0/0/0", imem_req, if_id_valid, if_id_inst);
        else n_pass++;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200})
            $display("FAIL rda_new_fetch got=%b/%h exp=1/200", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_rd_en_off();
        do_reset();
        inst_rd_en = 1'b1;
        step();
        imem_ack = 1'b1; inst_rd_en = 1'b0;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, if_id_valid, if_id_pc_plus4} !== {1'b0, 1'b1, 32'd4})
            $display("FAIL rde_last got=%b/%b/%h exp=0/1/4", imem_req, if_id_valid, if_id_pc_plus4);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if ({imem_req, if_id_valid, if_id_inst} !== {1'b0, 1'b0, 32'h0})
                $display("FAIL rde_bubble k=%0d got=%b/%b/%h exp=0/0/0", k, imem_req, if_id_valid, if_id_inst);
            else n_pass++;
        end
        inst_rd_en = 1'b1;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd4})
            $display("FAIL rde_resume got=%b/%h exp=1/4", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_midwait();
        do_reset();
        inst_rd_en = 1'b1;
        step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({imem_req, fetch_busy, if_id_valid, imem_addr, if_id_inst, if_id_pc_plus4} !== {3'b000, 96'h0})
            $display("FAIL rmw_reset got=%b%b%b/%h/%h/%h exp=000/0/0/0", imem_req, fetch_busy,
                     if_id_valid, imem_addr, if_id_inst, if_id_pc_plus4);
        else n_pass++;
        imem_ack = 1'b1; inst_rd_en = 1'b0;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, fetch_busy, if_id_valid} !== 3'b000)
            $display("FAIL rmw_late_ack got=%b exp=000", {imem_req, fetch_busy, if_id_valid});
        else n_pass++;
        inst_rd_en = 1'b1;
        step();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL rmw_refetch got=%b/%h exp=1/0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        inst_rd_en = 1'b1; select_new_pc = 1'b1; new_pc_addr = 32'hFFFF_FFF8;
        step();
        select_new_pc = 1'b0;
        step();
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc_plus4} !== {1'b1, 32'h0, 1'b1, 32'h0})
            $display("FAIL wrap got=%b/%h/%b/%h exp=1/0/1/0", imem_req, imem_addr, if_id_valid, if_id_pc_plus4);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst           = ($urandom_range(0, 299) == 0);
            inst_rd_en    = ($urandom_range(0, 9) < 8);
            stall         = ($urandom_range(0, 9) < 2);
            general_flush = ($urandom_range(0, 19) == 0);
            select_new_pc = ($urandom_range(0, 14) == 0);
            new_pc_addr   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 255)) << 2);
            imem_ack      = m_req && ($urandom_range(0, 1) == 1);
            step();
            n_checks++;
            if ({imem_req, fetch_busy, if_id_valid} !== {m_req, (m_req || m_skid_q.size() != 0), m_valid})
                $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {imem_req, fetch_busy, if_id_valid},
                         {m_req, (m_req || m_skid_q.size() != 0), m_valid});
            else n_pass++;
            n_checks++;
            if ({imem_addr, if_id_inst} !== {m_addr, m_inst})
                $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", cyc, imem_addr, if_id_inst, m_addr, m_inst);
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if (if_id_pc_plus4 !== m_pc4)
                    $display("FAIL rnd_pc4 cyc=%0d got=%h exp=%h", cyc, if_id_pc_plus4, m_pc4);
                else n_pass++;
            end
        end
        rst = 1'b0; general_flush = 1'b0; select_new_pc = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_rd_en = 1'b0; stall = 1'b0; general_flush = 1'b0;
        select_new_pc = 1'b0; new_pc_addr = 32'h0; imem_ack = 1'b0; imem_data = 32'h0;
        m_pc = 32'h0; m_req = 1'b0; m_addr = 32'h0; m_drop = 1'b0;
        m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        #1;
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_ack();
        test_rd_en_off();
        test_reset_midwait();
        test_pc_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
